per2_timer: RTL and testbench

PER2_TIMER -- requirements
Module: per2_timer

---
 rtl/per2_timer_if.sv | 23 ++
 rtl/per2_timer.sv | 183 ++++++++++++++++++
 tb/tb_per2_timer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/per2_timer_if.sv
// Bus-side signals of the PER2 timer peripheral, with master (core/bench)
// and slave (timer) views.
interface per2_timer_if;
    logic        per_en;
    logic        rd_en;
    logic        wr_en;
    logic [1:0]  size_select;
    logic [15:0] addr;
    logic [31:0] write_data;
    logic        busy_control;
    logic [31:0] read_data;
    logic        slave_ready;

    modport slave (
        input  per_en, rd_en, wr_en, size_select, addr, write_data, busy_control,
        output read_data, slave_ready
    );

    modport master (
        output per_en, rd_en, wr_en, size_select, addr, write_data, busy_control,
        input  read_data, slave_ready
    );
endinterface

// File: rtl/per2_timer.sv
// PER2 timer: prescaled 32-bit up-counter with compare/match, one-shot or
// auto-reload, interrupt, behind a four-state sized-access bus slave.
module per2_timer (
    input  logic        clk,
    input  logic        rst_n,
    per2_timer_if.slave bus,
    output logic        irq
);
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP, S_RELEASE} state_e;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [4:0]  addr;
        logic [31:0] wdata;
    } req_t;

    state_e      state_q, state_d;
    req_t        req_q, req_d;
    logic [31:0] rdata_q, rdata_d;
    logic        commit;

    logic        en_q, en_d, ar_q, ar_d, ie_q, ie_d;
    logic [15:0] prescale_q, prescale_d, psc_q, psc_d;
    logic [31:0] compare_q, compare_d, count_q, count_d;
    logic        match_q, match_d, irq_q;

    logic [3:0]  be;
    logic [31:0] bmask, wrep, wbits, cur, wr_val, rsel;
    logic        tick, match_set, do_wr;
    logic        unused_addr;

    assign unused_addr = ^bus.addr[15:5];

    // Bus FSM; the request is frozen into req_q when it is accepted.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        commit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.per_en && bus.rd_en) begin
                    state_d = S_ACCESS;
                    req_d   = '{wr: bus.wr_en, size: bus.size_select,
                                addr: bus.addr[4:0], wdata: bus.write_data};
                end
            end
            S_ACCESS: begin
                if (!bus.busy_control) begin
                    state_d = S_RESP;
                    commit  = 1'b1;
                end
            end
            S_RESP:    state_d = S_RELEASE;
            S_RELEASE: if (!bus.rd_en) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Byte enables and lane-replicated write data for sized accesses.
    always_comb begin
        be   = 4'b1111;
        wrep = req_q.wdata;
        case (req_q.size)
            2'b00: begin
                be   = 4'b0001 << req_q.addr[1:0];
                wrep = {4{req_q.wdata[7:0]}};
            end
            2'b01: begin
                be   = req_q.addr[1] ? 4'b1100 : 4'b0011;
                wrep = {2{req_q.wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign bmask  = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    assign wbits  = wrep & bmask;

    always_comb begin
        case (req_q.addr[4:2])
            3'd0:    cur = {29'b0, ie_q, ar_q, en_q};
            3'd1:    cur = {16'b0, prescale_q};
            3'd2:    cur = compare_q;
            3'd3:    cur = count_q;
            3'd4:    cur = {31'b0, match_q};
            default: cur = 32'b0;
        endcase
    end

    // The addressed register merged with the enabled lanes of write data.
    assign wr_val = (cur & ~bmask) | wbits;

    always_comb begin
        case (req_q.size)
            2'b00:   rsel = (cur >> {req_q.addr[1:0], 3'b000}) & 32'h0000_00FF;
            2'b01:   rsel = (cur >> {req_q.addr[1], 4'b0000}) & 32'h0000_FFFF;
            default: rsel = cur;
        endcase
    end

    assign do_wr   = commit && req_q.wr;
    assign rdata_d = commit ? (req_q.wr ? 32'b0 : rsel) : rdata_q;

    // Timer datapath; bus writes are applied last so they win over a tick.
    always_comb begin
        en_d       = en_q;
        ar_d       = ar_q;
        ie_d       = ie_q;
        prescale_d = prescale_q;
        compare_d  = compare_q;
        count_d    = count_q;
        psc_d      = 16'b0;
        match_set  = 1'b0;
        tick       = en_q && (psc_q == prescale_q);

        if (en_q) psc_d = tick ? 16'b0 : psc_q + 16'd1;
        if (tick) begin
            if (count_q == compare_q) begin
                match_set = 1'b1;
                if (ar_q) count_d = 32'b0;
                else      en_d    = 1'b0;
            end else begin
                count_d = count_q + 32'd1;
            end
        end

        if (do_wr) begin
            case (req_q.addr[4:2])
                3'd0: begin
                    en_d = wr_val[0];
                    ar_d = wr_val[1];
                    ie_d = wr_val[2];
                end
                3'd1: prescale_d = wr_val[15:0];
                3'd2: compare_d  = wr_val;
                3'd3: begin
                    count_d = wr_val;
                    psc_d   = 16'b0;
                end
                default: ;
            endcase
        end

        // A match in the same cycle as a W1C leaves MATCH set.
        match_d = match_set ||
                  (match_q && !(do_wr && req_q.addr[4:2] == 3'd4 && wbits[0]));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            req_q      <= '0;
            rdata_q    <= 32'b0;
            en_q       <= 1'b0;
            ar_q       <= 1'b0;
            ie_q       <= 1'b0;
            prescale_q <= 16'b0;
            psc_q      <= 16'b0;
            compare_q  <= 32'b0;
            count_q    <= 32'b0;
            match_q    <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            rdata_q    <= rdata_d;
            en_q       <= en_d;
            ar_q       <= ar_d;
            ie_q       <= ie_d;
            prescale_q <= prescale_d;
            psc_q      <= psc_d;
            compare_q  <= compare_d;
            count_q    <= count_d;
            match_q    <= match_d;
            irq_q      <= match_q && ie_q;
        end
    end

    assign bus.slave_ready = (state_q == S_RESP);
    assign bus.read_data   = (state_q == S_RESP) ? rdata_q : 32'b0;
    assign irq             = irq_q;
endmodule

// File: tb/tb_per2_timer.sv
// Scoreboard bench for per2_timer: read expectations are queued when the
// request is driven and compared when slave_ready pulses.
module tb_per2_timer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic irq;

    per2_timer_if bus();

    per2_timer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    int cyc = 0;
    int rdy_cnt = 0, rdata_leak = 0;
    int rise_cyc = -1, fall_cyc = -1;
    int cmt = 0, lat = 0;
    int w0 = 0;
    logic irq_prev = 1'b0;

    bit          sb_rd[$];
    logic [31:0] sb_exp[$];
    string       sb_tag[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (bus.slave_ready) begin
            rdy_cnt++;
            if (sb_rd.size() > 0) begin
                bit          r;
                logic [31:0] e;
                string       t;
                r = sb_rd.pop_front();
                e = sb_exp.pop_front();
                t = sb_tag.pop_front();
                if (r) chk(t, bus.read_data, e);
            end
        end else if (bus.read_data != 32'b0) begin
            rdata_leak++;
        end
        if (irq && !irq_prev) rise_cyc = cyc;
        if (!irq && irq_prev) fall_cyc = cyc;
        irq_prev = irq;
    end

    task automatic xfer(input bit wr, input logic [1:0] sz, input logic [15:0] a,
                        input logic [31:0] wd, input logic [31:0] exp, input string tag,
                        input int busy_n, input int hold_n);
        int  c0;
        bit  got;
        c0 = rdy_cnt;
        sb_rd.push_back(!wr);
        sb_exp.push_back(exp);
        sb_tag.push_back(tag);
        bus.per_en = 1'b1; bus.rd_en = 1'b1; bus.wr_en = wr;
        bus.size_select = sz; bus.addr = a; bus.write_data = wd;
        bus.busy_control = (busy_n > 0);
        @(posedge clk); #1;
        // Request is latched now; anything driven later must be ignored.
        bus.addr = 16'($urandom); bus.write_data = $urandom;
        bus.size_select = 2'($urandom); bus.wr_en = ~wr;
        lat = 1;
        for (int i = 0; i < busy_n; i++) begin
            @(posedge clk); #1;
            lat++;
            if (i == busy_n - 1) bus.busy_control = 1'b0;
        end
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            lat++;
            got = bus.slave_ready;
        end
        chk({tag, " ready"}, got, 1'b1);
        cmt = cyc;
        repeat (hold_n) @(posedge clk);
        if (hold_n > 0) #1;
        bus.rd_en = 1'b0; bus.per_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk({tag, " pulses"}, rdy_cnt - c0, 1);
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [1:0] sz = 2'b10);
        xfer(1'b1, sz, a, d, 32'b0, "wr", 0, 0);
    endtask

    task automatic rd(input string tag, input logic [15:0] a, input logic [31:0] e,
                      input logic [1:0] sz = 2'b10, input int busy_n = 0, input int hold_n = 0);
        xfer(1'b0, sz, a, 32'b0, e, tag, busy_n, hold_n);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        bus.per_en = 0; bus.rd_en = 0; bus.wr_en = 0; bus.size_select = 0;
        bus.addr = 0; bus.write_data = 0; bus.busy_control = 0;
        idle(3);
        chk("rst ready", bus.slave_ready, 1'b0);
        chk("rst rdata", bus.read_data, 32'b0);
        chk("rst irq", irq, 1'b0);
        rst_n = 1'b1;
        idle(1);

        rd("rst ctrl", 16'h00, 0); rd("rst psc", 16'h04, 0); rd("rst cmp", 16'h08, 0);
        rd("rst cnt", 16'h0C, 0);  rd("rst stat", 16'h10, 0);

        // Latency and wait states
        wr(16'h08, 32'h1122_3344);
        rd("cmp word", 16'h08, 32'h1122_3344);
        chk("lat nowait", lat, 2);
        rd("cmp busy", 16'h08, 32'h1122_3344, 2'b10, 3);
        chk("lat busy3", lat, 5);

        // Sized accesses
        wr(16'h0A, 32'h5555_55AB, 2'b00);
        rd("byte wr word", 16'h08, 32'h11AB_3344);
        rd("half rd 0A", 16'h0A, 32'h0000_11AB, 2'b01);
        rd("byte rd 0B", 16'h0B, 32'h0000_0011, 2'b00);
        rd("byte rd 08", 16'h08, 32'h0000_0044, 2'b00);
        wr(16'h0D, 32'h1234_CAFE, 2'b01);
        rd("half wr a0", 16'h0C, 32'h0000_CAFE);
        wr(16'h0F, 32'hDEAD_BEEF);
        rd("word wr a3", 16'h0C, 32'hDEAD_BEEF);
        wr(16'h00, 32'hFFFF_FFFA);
        rd("ctrl mask", 16'h00, 32'h0000_0002);

        // Unmapped offsets and upper address bits
        wr(16'h14, 32'h1234_5678);
        rd("unmap 14", 16'h14, 0);
        rd("unmap 1C", 16'h1C, 0);
        rd("alias 1008", 16'h1008, 32'h11AB_3344);
        rd("hold rd_en", 16'h04, 0, 2'b10, 0, 3);

        // Auto-reload, PRESCALE=0, COMPARE=5
        wr(16'h00, 0); wr(16'h04, 0); wr(16'h08, 5); wr(16'h0C, 0); wr(16'h10, 1);
        wr(16'h00, 7); w0 = cmt;
        rd("ar cnt 3", 16'h0C, 3);
        rd("ar cnt wrap", 16'h0C, 1);
        chk("ar irq rise", rise_cyc, w0 + 7);
        wr(16'h00, 0);
        rd("ar match", 16'h10, 1);
        idle(5);
        rd("frozen cnt", 16'h0C, 0);

        // COUNT write beats a concurrent tick
        wr(16'h08, 32'hFFFF_0000); wr(16'h00, 1);
        wr(16'h0C, 32'h100);
        rd("cnt wr prio", 16'h0C, 32'h103);
        wr(16'h00, 0);

        // 32-bit wrap
        wr(16'h08, 5); wr(16'h0C, 32'hFFFF_FFFE);
        wr(16'h00, 1);
        rd("cnt wrap", 16'h0C, 1);
        wr(16'h00, 0);

        // One-shot, PRESCALE=1, COMPARE=2
        wr(16'h10, 1); wr(16'h0C, 0); wr(16'h08, 2); wr(16'h04, 1);
        wr(16'h00, 5); w0 = cmt;
        idle(8);
        rd("os ctrl", 16'h00, 4);
        rd("os cnt", 16'h0C, 2);
        rd("os match", 16'h10, 1);
        chk("os irq rise", rise_cyc, w0 + 7);

        // W1C colliding with a match set
        wr(16'h00, 0); wr(16'h10, 1); wr(16'h0C, 0); wr(16'h04, 0); wr(16'h08, 3);
        wr(16'h00, 5); w0 = cmt;
        wr(16'h10, 1);
        chk("w1c same cyc", cmt, w0 + 4);
        rd("w1c set wins", 16'h10, 1);
        chk("w1c irq rise", rise_cyc, w0 + 5);
        wr(16'h10, 1); w0 = cmt;
        chk("w1c irq fall", fall_cyc, w0 + 1);
        rd("w1c cleared", 16'h10, 0);

        // Reset during ACCESS of a PRESCALE write
        bus.per_en = 1; bus.rd_en = 1; bus.wr_en = 1; bus.size_select = 2'b10;
        bus.addr = 16'h04; bus.write_data = 32'h0000_FFFF; bus.busy_control = 1;
        idle(2);
        w0 = rdy_cnt;
        rst_n = 1'b0;
        #3 rst_n = 1'b1;
        bus.busy_control = 0; bus.rd_en = 0; bus.per_en = 0;
        idle(4);
        chk("rst abort pulses", rdy_cnt - w0, 0);
        rd("rst abort psc", 16'h04, 0);
        rd("rst abort cmp", 16'h08, 0);

        chk("rdata idle zero", rdata_leak, 0);
        chk("sb drained", sb_rd.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
